vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Pixel-timing stage directly upstream and downstream of the frame buffer. It generates the horizontal/vertical pixel counters that drive the frame buffer's counter_H/counter_V inputs, and consumes its 1-bit colour output. Sync and blanking are delayed through a pipeline matched to the frame buffer's lookup latency, so h_sync, v_sync and rgb_out leave the chip time-aligned. Default timing is 640x480@60 (25.175 MHz pixel clock).

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
COLOUR_LAT, 2, clocks from counter change to matching colour input (1..7)
FG_RGB, 6'b111111, rgb_out value when colour=1
BG_RGB, 6'b000000, rgb_out value when colour=0 in visible area

Ports:
clk  input  1  pixel clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
counter_H  output  10  current horizontal position, to frame buffer
counter_V  output  10  current vertical position, to frame buffer
colour  input  1  pixel colour from frame buffer, valid COLOUR_LAT clocks after its counter pair
h_sync  output  1  horizontal sync, active-low, aligned to rgb_out
v_sync  output  1  vertical sync, active-low, aligned to rgb_out
rgb_out  output  6  {R1,G1,B1,R0,G0,B0} pixel drive; 0 during blanking
frame_start  output  1  1-clock pulse while counter_H=0 and counter_V=0 (undelayed)
display_on  output  1  visible-area flag, aligned to rgb_out

Behaviour:
- Derived: H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- counter_H increments every clock; at H_TOTAL-1 wraps to 0 and counter_V increments; counter_V at V_TOTAL-1 with counter_H at H_TOTAL-1 wraps to 0. Counters are registers, driven directly to ports.
- Undelayed flags from counters: vis = (H<H_VISIBLE)&&(V<V_VISIBLE); hs_n low when H in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751); vs_n low when V in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491).
- {vis, hs_n, vs_n} pass through a COLOUR_LAT-deep shift register, then an output register stage combined with colour: rgb_out = vis_d ? (colour ? FG_RGB : BG_RGB) : 6'b0. h_sync, v_sync, display_on registered in the same stage.
- Total latency counter pair -> h_sync/v_sync/rgb_out/display_on = COLOUR_LAT+1 clocks; colour sampled at COLOUR_LAT clocks, appears on rgb_out 1 clock later.
- Reset (reset=0 at clk edge): counters=0; every delay stage loaded with vis=0, hs_n=1, vs_n=1; outputs h_sync=1, v_sync=1, rgb_out=0, display_on=0. frame_start follows counters (1 during reset since counters=0). Reset mid-frame restarts at (0,0) on the next edge; no partial sync pulse emitted after reset deasserts until counters reach the sync window again.
- colour is ignored (rgb_out forced 0) whenever the delayed vis is 0, including any X during blanking.
- Single cycle with both line wrap and frame wrap: both counters go to 0 on the same edge.
- No handshake; free-running after reset release.

Test Plan:
- Reset held 5 clocks then released -> counter_H=0,counter_V=0,h_sync=1,v_sync=1,rgb_out=0,display_on=0 during reset; counter_H=1 one clock after release.
- Run one line, colour=1 -> counter_H 0..799 then wraps, counter_V 0->1 at same edge; h_sync low for exactly 96 clocks beginning 3 clocks (COLOUR_LAT+1) after counter_H=656.
- Run full frame -> v_sync low for exactly 2x800=1600 clocks starting 3 clocks after (H=0,V=490); frame_start pulses once per 420000 clocks.
- Colour pattern driven as model of counter_H[0] delayed 2 clocks -> rgb_out alternates 6'b111111/0 across visible pixels, display_on high exactly 640 clocks per visible line, rgb_out=0 for H 640..799 equivalents and V>=480.
- Colour forced X during blanking -> rgb_out stays 0, no X propagation.
- Reset asserted at (H=700,V=490) mid-sync -> next edge counters=0, h_sync=1, v_sync=1 after reset edge; normal timing resumes from (0,0).

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA pixel timing: free-running H/V counters to the frame buffer, with sync and
// blanking delayed to line up with the frame buffer's colour lookup latency.
module vga_sync_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int COLOUR_LAT = 2,
   parameter logic [5:0] FG_RGB = 6'b111111,
   parameter logic [5:0] BG_RGB = 6'b000000
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] counter_H,
   output logic [9:0] counter_V,
   input  logic       colour,
   output logic       h_sync,
   output logic       v_sync,
   output logic [5:0] rgb_out,
   output logic       frame_start,
   output logic       display_on
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam int         TAIL   = COLOUR_LAT - 1;

   typedef struct packed {
      logic vis;
      logic hs_n;
      logic vs_n;
   } flags_t;

   // Blanked, both syncs inactive.
   localparam flags_t IDLE = 3'b011;

   flags_t                  cur;
   flags_t [COLOUR_LAT-1:0] dly;

   always_ff @(posedge clk) begin
      if (!reset) begin
         counter_H <= '0;
         counter_V <= '0;
      end else if (counter_H == H_LAST) begin
         counter_H <= '0;
         counter_V <= (counter_V == V_LAST) ? 10'd0 : counter_V + 10'd1;
      end else begin
         counter_H <= counter_H + 10'd1;
      end
   end

   assign frame_start = (counter_H == 10'd0) && (counter_V == 10'd0);

   always_comb begin
      cur.vis  = (counter_H < H_VIS) && (counter_V < V_VIS);
      cur.hs_n = !((counter_H >= HS_BEG) && (counter_H <= HS_END));
      cur.vs_n = !((counter_V >= VS_BEG) && (counter_V <= VS_END));
   end

   // Flags ride alongside the frame buffer lookup; the last stage meets colour.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < COLOUR_LAT; i++) dly[i] <= IDLE;
         h_sync     <= 1'b1;
         v_sync     <= 1'b1;
         rgb_out    <= '0;
         display_on <= 1'b0;
      end else begin
         dly[0] <= cur;
         for (int i = 1; i < COLOUR_LAT; i++) dly[i] <= dly[i-1];
         h_sync     <= dly[TAIL].hs_n;
         v_sync     <= dly[TAIL].vs_n;
         display_on <= dly[TAIL].vis;
         rgb_out    <= dly[TAIL].vis ? (colour ? FG_RGB : BG_RGB) : 6'b0;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen on a shrunken raster, checked each cycle
// against a position-arithmetic model plus a few hand-computed totals.
module tb_vga_sync_gen;
   localparam int HV = 16, HF = 4, HS = 6, HB = 4;
   localparam int VV = 12, VF = 2, VS = 2, VB = 3;
   localparam int LAT = 2;
   localparam int HT = HV + HF + HS + HB;   // 30
   localparam int VT = VV + VF + VS + VB;   // 19
   localparam int FRAME = HT * VT;          // 570
   localparam logic [5:0] FG = 6'b111111;
   localparam logic [5:0] BG = 6'b010010;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       colour = 1'b0;
   logic [9:0] counter_H, counter_V;
   logic       h_sync, v_sync, frame_start, display_on;
   logic [5:0] rgb_out;

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .COLOUR_LAT(LAT), .FG_RGB(FG), .BG_RGB(BG)
   ) dut (
      .clk(clk), .reset(reset), .counter_H(counter_H), .counter_V(counter_V),
      .colour(colour), .h_sync(h_sync), .v_sync(v_sync), .rgb_out(rgb_out),
      .frame_start(frame_start), .display_on(display_on)
   );

   always #5 clk = ~clk;

   int   n = 0;           // non-reset edges since the last reset edge
   bit   started = 1'b0;
   int   n_cmp = 0, n_bad = 0;
   logic hs_prev = 1'b1;
   bit   stats_on = 1'b0;
   int   st_hs, st_vs, st_disp, st_fs;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (n=%0d)", name, got, exp, n);
      end
   endtask

   // Raster rules applied to the m-th position after reset.
   function automatic void flags(input int m, output bit vis, output bit hs_n, output bit vs_n);
      int mm, h, v;
      mm   = m % FRAME;
      h    = mm % HT;
      v    = mm / HT;
      vis  = (h < HV) && (v < VV);
      hs_n = !((h >= HV + HF) && (h < HV + HF + HS));
      vs_n = !((v >= VV + VF) && (v < VV + VF + VS));
   endfunction

   task automatic tick();
      logic       col_prev, rst_prev;
      bit         evis, ehs, evs, cvis, chs, cvs;
      logic [5:0] ergb;
      int         mm, m;
      col_prev = colour;
      rst_prev = reset;
      @(posedge clk);
      if (!rst_prev) begin n = 0; started = 1'b1; end
      else n++;
      #1;
      if (started) begin
         mm = n % FRAME;
         check("counter_H", 32'(counter_H), 32'(mm % HT));
         check("counter_V", 32'(counter_V), 32'(mm / HT));
         check("frame_start", 32'(frame_start), 32'(mm == 0));
         if (n >= LAT + 1) flags(n - LAT - 1, evis, ehs, evs);
         else begin evis = 1'b0; ehs = 1'b1; evs = 1'b1; end
         ergb = evis ? (col_prev ? FG : BG) : 6'b0;
         check("h_sync", 32'(h_sync), 32'(ehs));
         check("v_sync", 32'(v_sync), 32'(evs));
         check("display_on", 32'(display_on), 32'(evis));
         check("rgb_out", 32'(rgb_out), 32'(ergb));
         if (hs_prev === 1'b1 && h_sync === 1'b0)
            check("hs_fall_at_H", 32'(counter_H), 32'd23);
         hs_prev = h_sync;
         if (stats_on) begin
            st_hs   += (h_sync === 1'b0) ? 1 : 0;
            st_vs   += (v_sync === 1'b0) ? 1 : 0;
            st_disp += (display_on === 1'b1) ? 1 : 0;
            st_fs   += (frame_start === 1'b1) ? 1 : 0;
         end
      end
      // Colour for the pixel the DUT will pair it with; X where that pixel is blanked.
      m = n - LAT;
      if (m >= 0) flags(m, cvis, chs, cvs);
      else cvis = 1'b0;
      if (!cvis && $urandom_range(0, 1) == 1) colour = 1'bx;
      else colour = 1'($urandom_range(0, 1));
   endtask

   initial begin
      reset = 1'b0;
      repeat (5) tick();
      check("rst_H", 32'(counter_H), 32'd0);
      check("rst_rgb", 32'(rgb_out), 32'd0);
      reset = 1'b1;
      tick();
      check("H_after_release", 32'(counter_H), 32'd1);

      repeat (2 * FRAME) tick();

      st_hs = 0; st_vs = 0; st_disp = 0; st_fs = 0;
      stats_on = 1'b1;
      repeat (FRAME) tick();
      stats_on = 1'b0;
      check("hs_low_per_frame", 32'(st_hs), 32'd114);
      check("vs_low_per_frame", 32'(st_vs), 32'd60);
      check("disp_per_frame", 32'(st_disp), 32'd192);
      check("fs_per_frame", 32'(st_fs), 32'd1);

      // Reset inside both sync windows (H=25, V=14).
      for (int k = 0; k < 2 * FRAME && (n % FRAME) != 445; k++) tick();
      check("reach_mid_sync", 32'(n % FRAME), 32'd445);
      check("mid_hs_low", 32'(h_sync), 32'd0);
      check("mid_vs_low", 32'(v_sync), 32'd0);
      reset = 1'b0;
      tick();
      check("mid_rst_H", 32'(counter_H), 32'd0);
      check("mid_rst_V", 32'(counter_V), 32'd0);
      check("mid_rst_hs", 32'(h_sync), 32'd1);
      check("mid_rst_vs", 32'(v_sync), 32'd1);
      reset = 1'b1;
      repeat (FRAME + 50) tick();

      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(50, 600)) tick();
         reset = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
         reset = 1'b1;
      end
      repeat (FRAME) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
